// File: rtl/ascii2dec.sv
// ascii2dec: collects ASCII digits and spaces into three-digit frames and emits each
// frame as a fixed read-strobe burst. A clear byte raises a stretched clean pulse.
module ascii2dec #(
   parameter logic [7:0]  TERM         = 8'h0D,
   parameter logic [7:0]  CLR          = 8'h1B,
   parameter logic [3:0]  BLANK        = 4'hF,
   parameter int unsigned CLEAN_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] iDATA,
   input  logic       iVALID,
   output logic       oBUSY,
   output logic       oRD,
   output logic [3:0] oDEC,
   output logic       oCLEAN,
   output logic       oERR,
   output logic       oDROP
);

   typedef enum logic {COLLECT, EMIT} state_t;

   state_t     state, state_nxt;
   logic [1:0] cnt, cnt_nxt;
   logic [1:0] e, e_nxt;
   logic [3:0] d     [3];
   logic [3:0] d_nxt [3];
   logic [7:0] clean_cnt;
   logic       clean_load;
   logic       err_nxt, drop_nxt, busy_nxt, rd_nxt;
   logic [3:0] dec_nxt;
   logic       is_digit, is_space;

   assign is_digit = (iDATA >= 8'h30) && (iDATA <= 8'h39);
   assign is_space = (iDATA == 8'h20);

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      e_nxt      = e;
      err_nxt    = 1'b0;
      drop_nxt   = 1'b0;
      clean_load = 1'b0;
      for (int i = 0; i < 3; i++) d_nxt[i] = d[i];

      case (state)
         COLLECT: begin
            if (iVALID) begin
               if (is_digit || is_space) begin
                  for (int i = 0; i < 3; i++)
                     if (cnt == 2'(i)) d_nxt[i] = is_digit ? iDATA[3:0] : BLANK;
                  if (cnt == 2'd2) begin
                     state_nxt = EMIT;
                     e_nxt     = 2'd0;
                     cnt_nxt   = 2'd0;
                  end else begin
                     cnt_nxt = cnt + 2'd1;
                  end
               end else if (iDATA == TERM) begin
                  if (cnt != 2'd0) begin
                     for (int i = 0; i < 3; i++)
                        if (2'(i) >= cnt) d_nxt[i] = BLANK;
                     state_nxt = EMIT;
                     e_nxt     = 2'd0;
                     cnt_nxt   = 2'd0;
                  end
               end else if (iDATA == CLR) begin
                  cnt_nxt    = 2'd0;
                  clean_load = 1'b1;
                  for (int i = 0; i < 3; i++) d_nxt[i] = BLANK;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end

         EMIT: begin
            // A clear aborts the burst outright; anything else is dropped while e advances.
            if (iVALID && (iDATA == CLR)) begin
               state_nxt  = COLLECT;
               cnt_nxt    = 2'd0;
               e_nxt      = 2'd0;
               clean_load = 1'b1;
               for (int i = 0; i < 3; i++) d_nxt[i] = BLANK;
            end else begin
               drop_nxt = iVALID;
               if (e == 2'd3) begin
                  state_nxt = COLLECT;
                  e_nxt     = 2'd0;
               end else begin
                  e_nxt = e + 2'd1;
               end
            end
         end

         default: state_nxt = COLLECT;
      endcase

      busy_nxt = (state_nxt == EMIT);
      rd_nxt   = (state_nxt == EMIT) && (e_nxt != 2'd3);
      dec_nxt  = BLANK;
      if (state_nxt == EMIT) begin
         case (e_nxt)
            2'd0:    dec_nxt = BLANK;
            2'd1:    dec_nxt = d_nxt[0];
            2'd2:    dec_nxt = d_nxt[1];
            default: dec_nxt = d_nxt[2];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= COLLECT;
         cnt   <= 2'd0;
         e     <= 2'd0;
         for (int i = 0; i < 3; i++) d[i] <= BLANK;
         oBUSY <= 1'b0;
         oRD   <= 1'b0;
         oDEC  <= BLANK;
         oERR  <= 1'b0;
         oDROP <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         e     <= e_nxt;
         for (int i = 0; i < 3; i++) d[i] <= d_nxt[i];
         oBUSY <= busy_nxt;
         oRD   <= rd_nxt;
         oDEC  <= dec_nxt;
         oERR  <= err_nxt;
         oDROP <= drop_nxt;
      end
   end

   // clean_cnt holds the high cycles still owed after the current one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clean_cnt <= 8'd0;
         oCLEAN    <= 1'b0;
      end else if (clean_load) begin
         clean_cnt <= 8'(CLEAN_CYCLES - 1);
         oCLEAN    <= 1'b1;
      end else if (oCLEAN) begin
         if (clean_cnt == 8'd0) oCLEAN <= 1'b0;
         else                   clean_cnt <= clean_cnt - 8'd1;
      end
   end

endmodule
